// File: rtl/tfhe_pu_status_leds.sv
// Status LED stage: heartbeat, link/busy levels, activity stretchers, sticky error and link-drop flags.
// Optional build macro TFHE_PU_LED_ERR_BLINK_EN makes the error LED blink in phase with the heartbeat.
module tfhe_pu_status_leds #(
  parameter int HEARTBEAT_DIV  = 125000000,
  parameter int STRETCH_CYCLES = 25000000,
  parameter int ERR_W          = 4
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             user_lnk_up,
  input  logic             h2c_act,
  input  logic             c2h_act,
  input  logic             pu_busy,
  input  logic             pu_done,
  input  logic [ERR_W-1:0] err_in,
  input  logic             err_clear,
  output logic [ERR_W-1:0] err_cause,
  output logic [7:0]       leds
);

  localparam int HB_W = $clog2(HEARTBEAT_DIV);
  localparam int ST_W = $clog2(STRETCH_CYCLES + 1);
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_DIV - 1);
  localparam logic [ST_W-1:0] ST_LOAD = ST_W'(STRETCH_CYCLES);

  logic [HB_W-1:0]           hb_cnt_q, hb_cnt_d;
  logic                      hb_led_q, hb_led_d;
  logic                      lnk_q, lnk_d;
  logic                      drop_q, drop_d;
  logic [2:0][ST_W-1:0]      st_cnt_q, st_cnt_d;
  logic [2:0]                st_trig;
  logic [ERR_W-1:0]          err_cause_q, err_cause_d;
  logic                      err_led;
  logic [7:0]                leds_q, leds_d;

  always_comb begin
    hb_cnt_d = (hb_cnt_q == HB_LAST) ? '0 : hb_cnt_q + 1'b1;
    hb_led_d = hb_led_q ^ (hb_cnt_q == HB_LAST);
    lnk_d    = user_lnk_up;

    // Stretchers: a pulse always reloads to the full length, otherwise count down to zero.
    st_trig  = {pu_done, c2h_act, h2c_act};
    st_cnt_d = st_cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (st_trig[i]) begin
        st_cnt_d[i] = ST_LOAD;
      end else if (st_cnt_q[i] != '0) begin
        st_cnt_d[i] = st_cnt_q[i] - 1'b1;
      end
    end

    // New error or drop events win over a simultaneous clear.
    err_cause_d = err_clear ? err_in : (err_cause_q | err_in);
    drop_d      = (lnk_q & ~user_lnk_up) | (drop_q & ~err_clear);

`ifdef TFHE_PU_LED_ERR_BLINK_EN
    err_led = (|err_cause_d) & hb_led_d;
`else
    err_led = |err_cause_d;
`endif

    leds_d = {drop_d,
              err_led,
              (st_cnt_d[2] != '0),
              pu_busy,
              (st_cnt_d[1] != '0),
              (st_cnt_d[0] != '0),
              lnk_d,
              hb_led_d};
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      hb_cnt_q    <= '0;
      hb_led_q    <= 1'b0;
      lnk_q       <= 1'b0;
      drop_q      <= 1'b0;
      st_cnt_q    <= '0;
      err_cause_q <= '0;
      leds_q      <= '0;
    end else begin
      hb_cnt_q    <= hb_cnt_d;
      hb_led_q    <= hb_led_d;
      lnk_q       <= lnk_d;
      drop_q      <= drop_d;
      st_cnt_q    <= st_cnt_d;
      err_cause_q <= err_cause_d;
      leds_q      <= leds_d;
    end
  end

  assign err_cause = err_cause_q;
  assign leds      = leds_q;

endmodule

// File: tb/tb_tfhe_pu_status_leds.sv
// Bench for tfhe_pu_status_leds: directed timeline, reset abort, then random traffic against a timing model.
// Honours TFHE_PU_LED_ERR_BLINK_EN when compiled with it.
module tb_tfhe_pu_status_leds;

  localparam int HD = 4;
  localparam int SC = 3;
  localparam int EW = 4;

  logic          clk = 1'b0;
  logic          aresetn;
  logic          user_lnk_up, h2c_act, c2h_act, pu_busy, pu_done, err_clear;
  logic [EW-1:0] err_in;
  logic [EW-1:0] err_cause;
  logic [7:0]    leds;

  int n_compared = 0;
  int n_mismatch = 0;

  tfhe_pu_status_leds #(
    .HEARTBEAT_DIV (HD),
    .STRETCH_CYCLES(SC),
    .ERR_W         (EW)
  ) dut (
    .aclk       (clk),
    .aresetn    (aresetn),
    .user_lnk_up(user_lnk_up),
    .h2c_act    (h2c_act),
    .c2h_act    (c2h_act),
    .pu_busy    (pu_busy),
    .pu_done    (pu_done),
    .err_in     (err_in),
    .err_clear  (err_clear),
    .err_cause  (err_cause),
    .leds       (leds)
  );

  always #5 clk = ~clk;

  // Model: edges since reset release, edge index of the last pulse on each stretcher input.
  int            k;
  int            last_h, last_c, last_d;
  logic [EW-1:0] m_err;
  logic          m_lnk, m_busy, m_drop;
  logic [7:0]    exp_leds;
  bit            model_valid = 0;

  always @(posedge clk) begin
    if (!aresetn) begin
      k = 0; last_h = -1000; last_c = -1000; last_d = -1000;
      m_err = '0; m_lnk = 0; m_busy = 0; m_drop = 0;
    end else begin
      k = k + 1;
      if (h2c_act) last_h = k;
      if (c2h_act) last_c = k;
      if (pu_done) last_d = k;
      m_err  = err_clear ? err_in : (m_err | err_in);
      m_drop = (m_lnk && !user_lnk_up) || (m_drop && !err_clear);
      m_lnk  = user_lnk_up;
      m_busy = pu_busy;
    end
    exp_leds[0] = ((k / HD) % 2) == 1;
    exp_leds[1] = m_lnk;
    exp_leds[2] = (k - last_h) < SC;
    exp_leds[3] = (k - last_c) < SC;
    exp_leds[4] = m_busy;
    exp_leds[5] = (k - last_d) < SC;
`ifdef TFHE_PU_LED_ERR_BLINK_EN
    exp_leds[6] = (m_err != 0) && exp_leds[0];
`else
    exp_leds[6] = (m_err != 0);
`endif
    exp_leds[7] = m_drop;
    model_valid = 1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      n_compared++;
      if (leds !== exp_leds) begin
        n_mismatch++;
        $display("[TB] FAIL model_leds t=%0t got %h exp %h", $time, leds, exp_leds);
      end
      n_compared++;
      if (err_cause !== m_err) begin
        n_mismatch++;
        $display("[TB] FAIL model_err_cause t=%0t got %h exp %h", $time, err_cause, m_err);
      end
    end
  end

  task automatic applyStimulus(input logic lnk, input logic h2c, input logic c2h,
                               input logic busy, input logic done,
                               input logic [EW-1:0] err, input logic clr);
    user_lnk_up = lnk; h2c_act = h2c; c2h_act = c2h; pu_busy = busy;
    pu_done = done; err_in = err; err_clear = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatch++;
      $display("[TB] FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  logic lnk_r;

  initial begin
    aresetn = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 4'h0, 0);
    applyStimulus(0, 0, 0, 0, 0, 4'h0, 0);
    checkOutput("rst_leds", leds, 8'h00);
    checkOutput("rst_err_cause", {4'h0, err_cause}, 8'h00);
    aresetn = 1'b1;

    $display("[TB] directed timeline");
    for (int n = 1; n <= 30; n++) begin
      applyStimulus((n >= 3 && n <= 19),
                    (n == 10 || n == 12),
                    (n >= 20 && n <= 25),
                    (n >= 16 && n <= 18),
                    (n == 17),
                    (n == 5) ? 4'h2 : (n == 7) ? 4'h8 : (n == 14) ? 4'h1 : 4'h0,
                    (n == 9 || n == 14 || n == 24));
      case (n)
        1:  checkOutput("idle_after_release", leds, 8'h00);
        3:  checkOutput("lnk_up", {7'b0, leds[1]}, 8'h01);
        4:  checkOutput("hb_rise", {7'b0, leds[0]}, 8'h01);
        5: begin
          checkOutput("err_set_cause", {4'h0, err_cause}, 8'h02);
          checkOutput("err_set_led", {7'b0, leds[6]}, 8'h01);
        end
        7:  checkOutput("err_accumulate", {4'h0, err_cause}, 8'h0A);
        8:  checkOutput("hb_fall", {7'b0, leds[0]}, 8'h00);
        9: begin
          checkOutput("err_clr_cause", {4'h0, err_cause}, 8'h00);
          checkOutput("err_clr_led", {7'b0, leds[6]}, 8'h00);
        end
        10: checkOutput("h2c_on", {7'b0, leds[2]}, 8'h01);
        12: checkOutput("hb_rise2", {7'b0, leds[0]}, 8'h01);
        14: begin
          checkOutput("h2c_retrigger", {7'b0, leds[2]}, 8'h01);
          checkOutput("clr_and_set_cause", {4'h0, err_cause}, 8'h01);
          checkOutput("clr_and_set_led", {7'b0, leds[6]}, 8'h01);
        end
        15: checkOutput("h2c_off", {7'b0, leds[2]}, 8'h00);
        19: checkOutput("no_drop_yet", {7'b0, leds[7]}, 8'h00);
        20: begin
          checkOutput("lnk_down", {7'b0, leds[1]}, 8'h00);
          checkOutput("drop_set", {7'b0, leds[7]}, 8'h01);
        end
        24: begin
          checkOutput("drop_clr", {7'b0, leds[7]}, 8'h00);
          checkOutput("clr_cause2", {4'h0, err_cause}, 8'h00);
        end
        27: checkOutput("c2h_hold", {7'b0, leds[3]}, 8'h01);
        28: checkOutput("c2h_off", {7'b0, leds[3]}, 8'h00);
        default: ;
      endcase
    end

    $display("[TB] reset mid-operation");
    applyStimulus(1, 1, 1, 1, 1, 4'h4, 0);
    aresetn = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 4'h0, 0);
    checkOutput("midrst_leds", leds, 8'h00);
    checkOutput("midrst_err_cause", {4'h0, err_cause}, 8'h00);
    aresetn = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 4'h0, 0);
    applyStimulus(0, 0, 0, 0, 0, 4'h0, 0);
    applyStimulus(0, 0, 0, 0, 0, 4'h0, 0);
    checkOutput("post_rst_quiet", leds, 8'h00);
    applyStimulus(0, 0, 0, 0, 0, 4'h0, 0);
    checkOutput("post_rst_hb_only", leds, 8'h01);

    $display("[TB] random traffic");
    lnk_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      aresetn = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 15) == 0) lnk_r = ~lnk_r;
      applyStimulus(lnk_r,
                    ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 15) == 0) ? EW'($urandom_range(1, 15)) : 4'h0,
                    ($urandom_range(0, 23) == 0));
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule

// File: doc/tfhe_pu_status_leds.md
Name: tfhe_pu_status_leds

Overview:
- Status/indicator stage inside the TFHE processor block design; produces the 8-bit `leds` bus driven to the board pins by the top-level wrapper.
- Consumes the following and turns them into human-visible LED patterns:
  - PCIe link state
  - DMA host-to-card (H2C) and card-to-host (C2H) activity pulses
  - processor busy/done
  - error strobes
- Provides a heartbeat, pulse stretching, and sticky error/link-drop indication with software clear.

Parameters:
- HEARTBEAT_DIV, 125000000, cycles per heartbeat half-period (LED0 toggles every HEARTBEAT_DIV cycles); legal >= 2.
- STRETCH_CYCLES, 25000000, cycles an activity LED stays lit after its last triggering pulse; legal >= 1.
- ERR_W, 4, number of independent error strobe inputs.

Ports:
- aclk  in  1  single block clock (PCIe user clock domain); all inputs synchronous to it.
- aresetn  in  1  synchronous, active-low reset.
- user_lnk_up  in  1  PCIe link-up level.
- h2c_act  in  1  single-cycle pulse per H2C DMA beat accepted.
- c2h_act  in  1  single-cycle pulse per C2H DMA beat sent.
- pu_busy  in  1  processor busy level.
- pu_done  in  1  single-cycle pulse at end of a bootstrap batch.
- err_in  in  ERR_W  error strobes, any bit high for one or more cycles.
- err_clear  in  1  pulse; clears sticky error and link-drop state.
- err_cause  out  ERR_W  sticky OR of all err_in bits seen since last clear.
- leds  out  8  LED drive, active-high.

Behaviour:
- Reset: one clock and reset, as already decided; reset is synchronous, active-low on aresetn, sampled on rising aclk.
  - While aresetn=0 at a clock edge: all counters, leds, err_cause and internal registers are 0 at that edge.
  - Reset asserted mid-stretch or mid-heartbeat aborts immediately; no residual state.
- Latency: every output is registered. An input change sampled at edge t is visible on outputs after edge t (1-cycle latency).
- LED0 heartbeat:
  - Counter hb_cnt counts 0..HEARTBEAT_DIV-1 then wraps to 0.
  - LED0 toggles on the cycle hb_cnt wraps.
  - First toggle occurs HEARTBEAT_DIV cycles after reset release; period is 2*HEARTBEAT_DIV.
- LED1: registered user_lnk_up.
- LED2/LED3: retriggerable stretchers on h2c_act / c2h_act.
  - A pulse loads the counter with STRETCH_CYCLES; LED is high while counter != 0; counter decrements by 1 per cycle.
  - A pulse arriving while the counter is nonzero reloads it to STRETCH_CYCLES (no accumulation, no saturation issue).
  - Pulse held high continuously: LED stays high, then falls STRETCH_CYCLES cycles after the last high sample.
  - Counter width is clog2(STRETCH_CYCLES+1).
- LED4: registered pu_busy.
- LED5: stretcher identical to LED2, driven by pu_done.
- LED6: error sticky.
  - Set when any err_in bit is 1; err_cause |= err_in each cycle.
  - err_clear zeroes err_cause and LED6.
  - err_clear and err_in nonzero in the same cycle: set wins; err_cause becomes exactly that cycle's err_in (older bits cleared).
- LED7: link-drop sticky.
  - Set on a 1->0 transition of registered user_lnk_up; no set on the initial 0 after reset.
  - Cleared by err_clear; simultaneous drop and clear: set wins.
- No handshakes; inputs are never back-pressured.

Optional Feature:
- Macro TFHE_PU_LED_ERR_BLINK_EN.
- Defined: LED6 output = err_sticky AND LED0 heartbeat state, so the error LED blinks in phase with the heartbeat; err_cause is unaffected.
- Undefined: LED6 is solid while sticky error is set.
- Internal sticky register behaves identically in both builds.

Test Plan:
- Use HEARTBEAT_DIV=4, STRETCH_CYCLES=3, ERR_W=4, macro undefined unless stated.
- Reset and heartbeat: release aresetn at cycle 0 -> leds=0x00, err_cause=0x0 during reset; LED0 rises after edge 4, falls after edge 8, rises after edge 12.
- Stretcher retrigger: h2c_act pulse at cycle 10 -> LED2 high cycles 11-13. Second pulse at cycle 12 -> LED2 stays high through cycle 15, low at 16. c2h_act constant 1 for cycles 20-25 -> LED3 high 21-28.
- Error sticky and clear:
  - err_in=0x2 at cycle 5 -> LED6=1, err_cause=0x2 from cycle 6.
  - err_in=0x8 at cycle 7 -> err_cause=0xA.
  - err_clear at cycle 9 -> LED6=0, err_cause=0x0 from cycle 10.
  - err_clear together with err_in=0x1 -> err_cause=0x1, LED6=1.
- Link drop: user_lnk_up 0->1 at cycle 3 -> LED1 high from 4, LED7 stays 0. 1->0 at cycle 20 -> LED1 low and LED7 high within 2 cycles. err_clear -> LED7=0.
- Reset mid-operation: aresetn low at cycle 12 during active stretch with sticky error set -> leds=0x00, err_cause=0x0 next cycle. After release, no LED lights without new stimulus except the heartbeat.
- Macro TFHE_PU_LED_ERR_BLINK_EN defined, err_in=0x1 once -> LED6 equals LED0 every cycle thereafter until err_clear; err_cause=0x1 held.
